// File: rtl/fc_link_ctrl.sv
// FC MAC link bring-up/recovery sequencer (ff_tx_clk domain) with bounded retries.
// Optional flap statistics enabled by defining FC_LINK_CTRL_STATS_EN.
module fc_link_ctrl #(
    parameter int TIMEOUT_W = 24,
    parameter int RETRY_MAX = 3,
    parameter int SWRST_CYC = 8,
    localparam int RW = $clog2(RETRY_MAX + 1)
) (
    input  logic                 ff_tx_clk,
    input  logic                 reset_ff_tx_clk_n,
    input  logic                 link_en,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic                 sync_acqurd,
    input  logic                 node_on_line,
    input  logic                 node_fault,
    input  logic                 reset_link_ack,
    input  logic                 credit_reset_ack,
    output logic                 sw_reset_cmd,
    output logic                 on_line,
    output logic                 off_line,
    output logic                 reset_link,
    output logic                 credit_reset,
    output logic                 link_up,
    output logic                 link_fail,
    output logic [2:0]           link_state,
    output logic [RW-1:0]        retry_cnt,
    output logic [15:0]          link_flap_cnt
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SWRST      = 3'd1,
        WAIT_SYNC  = 3'd2,
        GO_ONLINE  = 3'd3,
        CREDIT_RST = 3'd4,
        UP         = 3'd5,
        LINK_RST   = 3'd6,
        FAIL       = 3'd7
    } state_t;

    localparam logic [TIMEOUT_W-1:0] SWRST_LD = TIMEOUT_W'(SWRST_CYC);

    state_t               state;
    logic [TIMEOUT_W-1:0] timer;
    logic                 to_en;
    logic                 exit_cond;
    logic                 wait_st;
    logic                 disable_req;
    logic                 expired;
    logic                 up_fault;

    always_comb begin
        exit_cond = 1'b0;
        case (state)
            WAIT_SYNC:  exit_cond = sync_acqurd;
            GO_ONLINE:  exit_cond = node_on_line;
            CREDIT_RST: exit_cond = credit_reset_ack;
            LINK_RST:   exit_cond = reset_link_ack;
            default:    exit_cond = 1'b0;
        endcase
    end

    assign wait_st     = (state == WAIT_SYNC) || (state == GO_ONLINE) ||
                         (state == CREDIT_RST) || (state == LINK_RST);
    assign disable_req = !link_en && (state != IDLE) && (state != FAIL);
    // A zero timeout is latched as to_en=0 so the wait never expires.
    assign expired     = wait_st && !exit_cond && to_en && (timer == '0);
    assign up_fault    = (state == UP) && (node_fault || !sync_acqurd);
    assign link_state  = state;

    always_ff @(posedge ff_tx_clk or negedge reset_ff_tx_clk_n) begin
        if (!reset_ff_tx_clk_n) begin
            state        <= IDLE;
            timer        <= '0;
            to_en        <= 1'b0;
            retry_cnt    <= '0;
            sw_reset_cmd <= 1'b0;
            on_line      <= 1'b0;
            off_line     <= 1'b0;
            reset_link   <= 1'b0;
            credit_reset <= 1'b0;
            link_up      <= 1'b0;
            link_fail    <= 1'b0;
        end else begin
            on_line  <= 1'b0;
            off_line <= 1'b0;
            if (disable_req) begin
                state        <= IDLE;
                off_line     <= 1'b1;
                sw_reset_cmd <= 1'b0;
                reset_link   <= 1'b0;
                credit_reset <= 1'b0;
                link_up      <= 1'b0;
                retry_cnt    <= '0;
                timer        <= '0;
            end else if (expired) begin
                reset_link   <= 1'b0;
                credit_reset <= 1'b0;
                if (retry_cnt == RW'(RETRY_MAX)) begin
                    state     <= FAIL;
                    link_fail <= 1'b1;
                end else begin
                    retry_cnt    <= retry_cnt + 1'b1;
                    state        <= SWRST;
                    sw_reset_cmd <= 1'b1;
                    timer        <= SWRST_LD;
                end
            end else begin
                case (state)
                    IDLE: if (link_en) begin
                        state        <= SWRST;
                        sw_reset_cmd <= 1'b1;
                        timer        <= SWRST_LD;
                    end
                    SWRST: begin
                        if (timer <= 1) begin
                            state        <= WAIT_SYNC;
                            sw_reset_cmd <= 1'b0;
                            timer        <= cfg_timeout;
                            to_en        <= |cfg_timeout;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    UP: if (up_fault) begin
                        state      <= LINK_RST;
                        link_up    <= 1'b0;
                        reset_link <= 1'b1;
                        timer      <= cfg_timeout;
                        to_en      <= |cfg_timeout;
                    end
                    FAIL: if (!link_en) begin
                        state     <= IDLE;
                        link_fail <= 1'b0;
                        retry_cnt <= '0;
                    end
                    default: begin
                        // Remaining states are the timed waits.
                        if (exit_cond) begin
                            timer <= cfg_timeout;
                            to_en <= |cfg_timeout;
                            case (state)
                                WAIT_SYNC: begin
                                    state   <= GO_ONLINE;
                                    on_line <= 1'b1;
                                end
                                GO_ONLINE: begin
                                    state        <= CREDIT_RST;
                                    credit_reset <= 1'b1;
                                end
                                CREDIT_RST: begin
                                    state        <= UP;
                                    credit_reset <= 1'b0;
                                    link_up      <= 1'b1;
                                    retry_cnt    <= '0;
                                end
                                default: begin
                                    state      <= WAIT_SYNC;
                                    reset_link <= 1'b0;
                                end
                            endcase
                        end else if (timer != '0) begin
                            timer <= timer - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

`ifdef FC_LINK_CTRL_STATS_EN
    logic [15:0] flap_cnt;

    always_ff @(posedge ff_tx_clk or negedge reset_ff_tx_clk_n) begin
        if (!reset_ff_tx_clk_n)
            flap_cnt <= '0;
        else if (up_fault && link_en && (flap_cnt != 16'hFFFF))
            flap_cnt <= flap_cnt + 16'd1;
    end

    assign link_flap_cnt = flap_cnt;
`else
    assign link_flap_cnt = '0;
`endif

endmodule
